// File: rtl/bus_responder_8088.sv
// 8088 minimum-mode bus slave: decodes ALE cycles and serves a byte-wide RAM window on ad.
// Optional write protection (wp, err_clr, wr_err) is built when WRITE_PROTECT_EN is defined.
module bus_responder_8088 #(
    parameter logic [19:0] BASE_ADDR = 20'hF0000,
    parameter int          ADDR_BITS = 12,
    parameter bit          IO_SPACE  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] a,
    input  logic        ale,
    input  logic        iom,
    input  logic        dtr,
    input  logic        den_n,
    input  logic        rd_n,
    input  logic        wr_n,
    inout  wire  [7:0]  ad,
    output logic        sel,
    output logic        busy
`ifdef WRITE_PROTECT_EN
    ,
    input  logic        wp,
    input  logic        err_clr,
    output logic        wr_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_READ,
        ST_WCAP,
        ST_WCOMMIT,
        ST_WDONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   adr_q, adr_d;
    logic [7:0]             rdata_q, rdata_d;
    logic [7:0]             wdata_q, wdata_d;
    logic [7:0]             mem [DEPTH];

    logic                   hit;
    logic                   commit_req;
    logic                   commit_en;
    logic                   ad_oe;
    logic [ADDR_BITS-1:0]   offset;

    assign offset = a[ADDR_BITS-1:0];
    assign hit    = ale && (iom == IO_SPACE) && (a[19:ADDR_BITS] == BASE_ADDR[19:ADDR_BITS]);

    // A malformed cycle (ALE while the write is still in flight) commits early.
    assign commit_req = (state_q == ST_WCOMMIT) || ((state_q == ST_WCAP) && ale);

`ifdef WRITE_PROTECT_EN
    logic wr_err_q;

    assign commit_en = commit_req && !wp;
    assign wr_err    = wr_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_err_q <= 1'b0;
        end else if (commit_req && wp) begin
            wr_err_q <= 1'b1;
        end else if (err_clr) begin
            wr_err_q <= 1'b0;
        end
    end
`else
    assign commit_en = commit_req;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
        end
    end

    // NOTE: the array is deliberately left out of reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (commit_en) begin
            mem[adr_q] <= wdata_q;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (ale) begin
            state_d = hit ? ST_SEL : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:    state_d = ST_IDLE;
                ST_SEL: begin
                    if (!rd_n)      state_d = ST_READ;
                    else if (!wr_n) state_d = ST_WCAP;
                end
                ST_READ:    state_d = rd_n ? ST_IDLE : ST_READ;
                ST_WCAP:    state_d = ST_WCOMMIT;
                ST_WCOMMIT: state_d = ST_WDONE;
                ST_WDONE:   state_d = wr_n ? ST_IDLE : ST_WDONE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        adr_d   = adr_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        if (hit) begin
            adr_d = offset;
            // Forward the byte committing on this edge instead of the stale array word.
            rdata_d = (commit_en && (adr_q == offset)) ? wdata_q : mem[offset];
        end
        if ((state_q == ST_SEL) && !ale && rd_n && !wr_n) begin
            wdata_d = ad;
        end
    end

    always_comb begin
        sel   = (state_q != ST_IDLE);
        busy  = (state_q == ST_WCAP) || (state_q == ST_WCOMMIT);
        ad_oe = ((state_q == ST_SEL) || (state_q == ST_READ))
                && !rd_n && !dtr && !den_n && !ale;
    end

    assign ad = ad_oe ? rdata_q : 8'bz;

endmodule

// File: tb/tb_bus_responder_8088.sv
// Randomised scoreboard bench for bus_responder_8088: stimulus pushes expected transfers,
// a negedge monitor pops and checks them; a byte-level memory model supplies read data.
module tb_bus_responder_8088;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] a = '0;
    logic        ale = 1'b0, iom = 1'b0, dtr = 1'b1, den_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    wire  [7:0]  ad;
    logic        sel, busy;
    logic [7:0]  tb_ad = '0;
    logic        tb_ad_oe = 1'b0;
    bit          wp_on = 1'b0;
`ifdef WRITE_PROTECT_EN
    logic        wp = 1'b0, err_clr = 1'b0, wr_err;
`endif

    always #5 clk = ~clk;

    // CPU side drives ad only during write data phases; an undriven bus floats high.
    assign ad = tb_ad_oe ? tb_ad : 8'bz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (ad[i]);
    end

    bus_responder_8088 dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .ale   (ale),
        .iom   (iom),
        .dtr   (dtr),
        .den_n (den_n),
        .rd_n  (rd_n),
        .wr_n  (wr_n),
        .ad    (ad),
        .sel   (sel),
        .busy  (busy)
`ifdef WRITE_PROTECT_EN
        ,
        .wp      (wp),
        .err_clr (err_clr),
        .wr_err  (wr_err)
`endif
    );

    typedef struct {
        bit         is_read;
        bit         hit;
        logic [7:0] data;
        int         exp_busy;
    } xfer_t;

    xfer_t      sb[$];
    logic [7:0] model_mem [int];
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Window is F0000..F0FFF in memory space.
    function automatic bit model_hit(input logic [19:0] addr, input logic io);
        return (io == 1'b0) && (addr[19:12] == 8'hF0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n_low: cycles with wr_n low; n_tail: cycles with strobe high before the next ALE.
    task automatic do_write(input logic [19:0] addr, input logic io, input logic [7:0] data,
                            input int n_low, input int n_tail);
        xfer_t x;
        int    rem;
        x.is_read = 1'b0;
        x.hit     = model_hit(addr, io);
        x.data    = data;
        rem       = n_low - 1 + n_tail;
        // Busy spans capture-to-commit: two cycles, or one if the next ALE lands in WCAP.
        x.exp_busy = x.hit ? ((rem >= 1) ? 2 : 1) : 0;
        sb.push_back(x);
        if (x.hit && !wp_on) model_mem[int'(addr)] = data;
        a = addr; iom = io; ale = 1'b1; rd_n = 1'b1; wr_n = 1'b1; den_n = 1'b1; dtr = 1'b1;
        tb_ad_oe = 1'b0;
        tick();
        ale = 1'b0; wr_n = 1'b0; den_n = 1'b0; tb_ad = data; tb_ad_oe = 1'b1;
        repeat (n_low) tick();
        wr_n = 1'b1; den_n = 1'b1; tb_ad_oe = 1'b0;
        repeat (n_tail) tick();
    endtask

    task automatic do_read(input logic [19:0] addr, input logic io, input int n_low);
        xfer_t x;
        x.is_read  = 1'b1;
        x.hit      = model_hit(addr, io);
        x.data     = (x.hit && model_mem.exists(int'(addr))) ? model_mem[int'(addr)] : 8'h00;
        x.exp_busy = 0;
        sb.push_back(x);
        a = addr; iom = io; ale = 1'b1; rd_n = 1'b1; wr_n = 1'b1; den_n = 1'b1; dtr = 1'b0;
        tb_ad_oe = 1'b0;
        tick();
        ale = 1'b0; rd_n = 1'b0; den_n = 1'b0;
        repeat (n_low) tick();
        rd_n = 1'b1; den_n = 1'b1;
        tick();
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    xfer_t cur;
    bit    have_cur = 1'b0;
    int    busy_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_sel", 32'(sel), 32'd0);
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_ad_z", 32'(ad), 32'hFF);
            have_cur = 1'b0;
            busy_cnt = 0;
        end else if (ale) begin
            if (busy) busy_cnt++;
            if (have_cur && !cur.is_read) check("busy_cycles", 32'(busy_cnt), 32'(cur.exp_busy));
            check("ad_z_ale", 32'(ad), 32'hFF);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: ALE seen with no expected transfer at %0t", $time);
                have_cur = 1'b0;
            end else begin
                cur      = sb.pop_front();
                have_cur = 1'b1;
            end
            busy_cnt = 0;
        end else if (have_cur) begin
            if (busy) busy_cnt++;
            if (cur.is_read) begin
                if (!rd_n) begin
                    check("read_sel", 32'(sel), 32'(cur.hit));
                    check("read_data", 32'(ad), cur.hit ? 32'(cur.data) : 32'hFF);
                end else begin
                    check("ad_z_tail", 32'(ad), 32'hFF);
                end
            end else if (!wr_n) begin
                check("write_sel", 32'(sel), 32'(cur.hit));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pool[$] = '{12'h000, 12'h001, 12'h002, 12'h7FF, 12'h800, 12'hFFE, 12'hFFF};
        logic [19:0] addr;
        logic [7:0]  data;
        int          op;

        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Write then read.
        do_write(20'hF0010, 1'b0, 8'hA5, 2, 1);
        do_read (20'hF0010, 1'b0, 2);

        // Misses: outside window, wrong space, and a write in I/O space that must not land.
        do_read (20'hE0010, 1'b0, 2);
        do_read (20'hF0010, 1'b1, 2);
        do_write(20'hF0010, 1'b1, 8'h99, 2, 1);
        do_read (20'hF0010, 1'b0, 2);

        // Word write/read as two byte cycles, first byte with a third strobe cycle.
        do_write(20'hF0020, 1'b0, 8'h34, 3, 1);
        do_write(20'hF0021, 1'b0, 8'h12, 2, 1);
        do_read (20'hF0020, 1'b0, 3);
        do_read (20'hF0021, 1'b0, 2);

        // Word straddling the window top: only the low byte is served.
        do_write(20'hF0FFF, 1'b0, 8'hAB, 3, 1);
        do_write(20'hF1000, 1'b0, 8'hCD, 2, 1);
        do_read (20'hF0FFF, 1'b0, 3);
        do_read (20'hF1000, 1'b0, 2);

        // Forwarding: ALE to the same offset during WCOMMIT, then during WCAP.
        do_write(20'hF0030, 1'b0, 8'h3C, 2, 1);
        do_write(20'hF0030, 1'b0, 8'h5A, 2, 0);
        do_read (20'hF0030, 1'b0, 2);
        do_write(20'hF0031, 1'b0, 8'h11, 2, 1);
        do_write(20'hF0031, 1'b0, 8'h6E, 1, 0);
        do_read (20'hF0031, 1'b0, 2);

        // Reset while a write of FF sits in WCAP: it must be discarded.
        do_write(20'hF0040, 1'b0, 8'h00, 2, 1);
        begin
            xfer_t x;
            x.is_read = 1'b0; x.hit = 1'b1; x.data = 8'hFF; x.exp_busy = 2;
            sb.push_back(x);
        end
        a = 20'hF0040; iom = 1'b0; ale = 1'b1; dtr = 1'b1;
        tick();
        ale = 1'b0; wr_n = 1'b0; den_n = 1'b0; tb_ad = 8'hFF; tb_ad_oe = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1; wr_n = 1'b1; den_n = 1'b1; tb_ad_oe = 1'b0;
        tick();
        do_read(20'hF0040, 1'b0, 2);

`ifdef WRITE_PROTECT_EN
        do_write(20'hF0050, 1'b0, 8'h11, 2, 1);
        wp = 1'b1; wp_on = 1'b1;
        do_write(20'hF0050, 1'b0, 8'h77, 2, 1);
        wp = 1'b0; wp_on = 1'b0;
        check("wr_err_set", 32'(wr_err), 32'd1);
        tick();
        check("wr_err_sticky", 32'(wr_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("wr_err_clear", 32'(wr_err), 32'd0);
        do_read(20'hF0050, 1'b0, 2);
`endif

        // Random phase over a pool of offsets, including both window edges.
        foreach (pool[i]) do_write(20'hF0000 | 20'(pool[i]), 1'b0, 8'($urandom_range(0, 254)), 2, 1);
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: do_write(20'hF0000 | 20'(pool[$urandom_range(0, pool.size() - 1)]), 1'b0,
                            8'($urandom_range(0, 254)), $urandom_range(1, 3), $urandom_range(0, 1));
                1: do_read(20'hF0000 | 20'(pool[$urandom_range(0, pool.size() - 1)]), 1'b0,
                           $urandom_range(2, 3));
                2: begin
                    addr = 20'($urandom);
                    if (addr[19:12] == 8'hF0) addr[12] = 1'b1;
                    do_read(addr, 1'($urandom_range(0, 1)), 2);
                end
                default: begin
                    addr = 20'hF0000 | 20'(pool[$urandom_range(0, pool.size() - 1)]);
                    data = 8'($urandom_range(0, 254));
                    do_write(addr, 1'b1, data, 2, 1);
                end
            endcase
        end

        // Closing transfer finalises the last write's busy count.
        do_read(20'h00000, 1'b0, 2);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL sb_drain: %0d transfers never observed, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
